// File: rtl/xgriscv_run_pkg.sv
// rtl/xgriscv_run_pkg.sv - shared encodings for the xgriscv run/debug sequencer
package xgriscv_run_pkg;

    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4,
        ST_TMO  = 3'd5
    } run_state_e;

    typedef enum logic [1:0] {
        HC_NONE     = 2'd0,
        HC_BP       = 2'd1,
        HC_HALT_REQ = 2'd2,
        HC_STEP     = 2'd3
    } halt_cause_e;

endpackage

// File: rtl/xgriscv_sat_cnt.sv
// rtl/xgriscv_sat_cnt.sv - saturating up-counter with synchronous clear and increment enable
module xgriscv_sat_cnt
    import xgriscv_run_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/xgriscv_run_ctrl.sv
// rtl/xgriscv_run_ctrl.sv - run/debug sequencer for xgriscv_sc (watchdog: XGRISCV_RUN_WATCHDOG_EN)
module xgriscv_run_ctrl
    import xgriscv_run_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = DEFAULT_CNT_W,
    parameter int MAX_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             resume,
    input  logic             step,
    input  logic             halt_req,
    input  logic             bp_valid,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pcW,
    input  logic             retire,
    output logic             core_rst,
    output logic             core_en,
    output logic [2:0]       state,
    output logic [1:0]       halt_cause,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RST_CYCLES - 1);

    generate
        if (RST_CYCLES < 1 || MAX_CYCLES < 1) begin : g_bad_cfg
            $error("xgriscv_run_ctrl: RST_CYCLES and MAX_CYCLES must be >= 1");
        end
    endgenerate

    run_state_e      state_q, state_d;
    halt_cause_e     halt_cause_q, halt_cause_d;
    logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
    logic            timeout_q, timeout_d;

    logic active;
    logic bp_hit;
    logic wd_hit;
    logic cnt_clr;

    assign active = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign bp_hit = retire && bp_valid && (pcW == bp_addr);

`ifdef XGRISCV_RUN_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES - 1);
    // Fires on the cycle that would take cycle_cnt up to MAX_CYCLES.
    assign wd_hit = active && (cycle_cnt == WD_LIMIT);
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        rst_cnt_d    = rst_cnt_q;
        timeout_d    = timeout_q;
        cnt_clr      = 1'b0;

        if (start) begin
            state_d      = ST_RST;
            rst_cnt_d    = RST_LOAD;
            halt_cause_d = HC_NONE;
            timeout_d    = 1'b0;
            cnt_clr      = 1'b1;
        end else begin
            unique case (state_q)
                ST_RST: begin
                    if (rst_cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        rst_cnt_d = rst_cnt_q - RC_W'(1);
                    end
                end
                ST_RUN: begin
                    if (wd_hit) begin
                        state_d   = ST_TMO;
                        timeout_d = 1'b1;
                    end else if (bp_hit) begin
                        state_d      = ST_HALT;
                        halt_cause_d = HC_BP;
                    end else if (halt_req) begin
                        state_d      = ST_HALT;
                        halt_cause_d = HC_HALT_REQ;
                    end
                end
                ST_STEP: begin
                    if (wd_hit) begin
                        state_d   = ST_TMO;
                        timeout_d = 1'b1;
                    end else begin
                        state_d      = ST_HALT;
                        halt_cause_d = bp_hit ? HC_BP : HC_STEP;
                    end
                end
                ST_HALT: begin
                    if (step) begin
                        state_d = ST_STEP;
                    end else if (resume) begin
                        state_d      = ST_RUN;
                        halt_cause_d = HC_NONE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q      <= ST_IDLE;
            halt_cause_q <= HC_NONE;
            rst_cnt_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_cause_q <= halt_cause_d;
            rst_cnt_q    <= rst_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    xgriscv_sat_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rstn),
        .clr (cnt_clr),
        .inc (active),
        .cnt (cycle_cnt)
    );

    xgriscv_sat_cnt #(.CNT_W(CNT_W)) u_instr_cnt (
        .clk (clk),
        .rst (rstn),
        .clr (cnt_clr),
        .inc (active && retire),
        .cnt (instr_cnt)
    );

    assign core_rst   = (state_q == ST_IDLE) || (state_q == ST_RST);
    assign core_en    = (state_q == ST_RST) || (state_q == ST_RUN) || (state_q == ST_STEP);
    assign state      = state_q;
    assign halt_cause = halt_cause_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_xgriscv_run_ctrl.sv
// tb/tb_xgriscv_run_ctrl.sv - self-checking bench for xgriscv_run_ctrl
`timescale 1ns/1ps
module tb_xgriscv_run_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STEP = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;
    localparam logic [2:0] S_TMO  = 3'd5;

    logic        clk;
    logic        rstn;
    logic        start, resume, step, halt_req, bp_valid, retire;
    logic [31:0] bp_addr, pcW;
    logic        core_rst, core_en, timeout;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt, instr_cnt;

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  hc;
        logic [31:0] ic;
        logic [31:0] cc;
    } obs_t;

    obs_t exp_q[$];
    obs_t e;
    obs_t got;

    int n_checks = 0;
    int n_fail   = 0;

    xgriscv_run_ctrl #(.RST_CYCLES(4), .CNT_W(32), .MAX_CYCLES(50)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .resume     (resume),
        .step       (step),
        .halt_req   (halt_req),
        .bp_valid   (bp_valid),
        .bp_addr    (bp_addr),
        .pcW        (pcW),
        .retire     (retire),
        .core_rst   (core_rst),
        .core_en    (core_en),
        .state      (state),
        .halt_cause (halt_cause),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #0.001 rstn = 1'b1;
        #0.005 rstn = 1'b0;
        got = {state, halt_cause, instr_cnt, cycle_cnt};
        n_checks++;
        if (got !== obs_t'{S_IDLE, 2'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_state got %h want %h", got, obs_t'{S_IDLE, 2'd0, 32'd0, 32'd0});
        end
        n_checks++;
        if ({core_rst, core_en, timeout} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_outputs got rst/en/tmo=%b want 100", {core_rst, core_en, timeout});
        end
        @(negedge clk);
        repeat (3) cyc();
        n_checks++;
        if (state !== S_IDLE || core_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_hold got state=%0d core_rst=%b want 0/1", state, core_rst);
        end
    endtask

    task automatic test_start();
        int n_rst;
        n_rst = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 10 && core_rst === 1'b1; i++) begin
            n_rst++;
            cyc();
        end
        n_checks++;
        if (n_rst !== 4) begin
            n_fail++;
            $display("FAIL start_rst_len got %0d cycles want 4", n_rst);
        end
        n_checks++;
        if (state !== S_RUN || core_en !== 1'b1 || core_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL start_run got state=%0d en=%b rst=%b want 2/1/0", state, core_en, core_rst);
        end
    endtask

    task automatic test_breakpoint();
        do_start();
        bp_valid = 1'b1;
        bp_addr  = 32'h50;
        for (int i = 0; i <= 20; i++) begin
            pcW    = 32'(4 * i);
            retire = 1'b1;
            exp_q.push_back(obs_t'{(i == 20) ? S_HALT : S_RUN, (i == 20) ? 2'd1 : 2'd0,
                                   32'(i + 1), 32'(i + 1)});
            cyc();
            e   = exp_q.pop_front();
            got = {state, halt_cause, instr_cnt, cycle_cnt};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL bp_run[%0d] got %h want %h", i, got, e);
            end
        end
        for (int j = 0; j < 10; j++) begin
            pcW = 32'h54 + 32'(4 * j);
            exp_q.push_back(obs_t'{S_HALT, 2'd1, 32'd21, 32'd21});
            cyc();
            e   = exp_q.pop_front();
            got = {state, halt_cause, instr_cnt, cycle_cnt};
            n_checks++;
            if (got !== e || core_en !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_frozen[%0d] got %h en=%b want %h en=0", j, got, core_en, e);
            end
        end
    endtask

    task automatic test_step();
        int en_cnt;
        en_cnt = 0;
        retire = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pcW  = 32'h200 + 32'(4 * k);
            step = 1'b1;
            exp_q.push_back(obs_t'{S_STEP, (k == 0) ? 2'd1 : 2'd3, 32'(21 + k), 32'(21 + k)});
            cyc();
            if (core_en === 1'b1) en_cnt++;
            step = 1'b0;
            exp_q.push_back(obs_t'{S_HALT, 2'd3, 32'(22 + k), 32'(22 + k)});
            cyc();
            if (core_en === 1'b1) en_cnt++;
            exp_q.push_back(obs_t'{S_HALT, 2'd3, 32'(22 + k), 32'(22 + k)});
            cyc();
            if (core_en === 1'b1) en_cnt++;
            for (int p = 0; p < 3; p++) begin
                e = exp_q.pop_front();
                n_checks++;
                if (p == 0) got = obs_t'{S_STEP, 2'd0, 32'd0, 32'd0};
                got = {state, halt_cause, instr_cnt, cycle_cnt};
                if (p < 2) begin
                    n_checks--;
                end else if (got !== e) begin
                    n_fail++;
                    $display("FAIL step_final[%0d] got %h want %h", k, got, e);
                end
            end
        end
        n_checks++;
        if (en_cnt !== 3) begin
            n_fail++;
            $display("FAIL step_en_cycles got %0d want 3", en_cnt);
        end
        n_checks++;
        if (instr_cnt !== 32'd24) begin
            n_fail++;
            $display("FAIL step_instr got %0d want 24", instr_cnt);
        end
    endtask

    task automatic test_resume_halt();
        retire = 1'b0;
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        n_checks++;
        if (state !== S_RUN || halt_cause !== 2'd0) begin
            n_fail++;
            $display("FAIL resume got state=%0d cause=%0d want 2/0", state, halt_cause);
        end
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        got = {state, halt_cause, instr_cnt, cycle_cnt};
        n_checks++;
        if (got !== obs_t'{S_HALT, 2'd2, 32'd24, 32'd25}) begin
            n_fail++;
            $display("FAIL halt_req got %h want %h", got, obs_t'{S_HALT, 2'd2, 32'd24, 32'd25});
        end
    endtask

    task automatic test_simultaneous();
        do_start();
        bp_valid = 1'b1;
        bp_addr  = 32'h50;
        pcW      = 32'h50;
        retire   = 1'b1;
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        retire   = 1'b0;
        got = {state, halt_cause, instr_cnt, cycle_cnt};
        n_checks++;
        if (got !== obs_t'{S_HALT, 2'd1, 32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL bp_vs_halt got %h want %h", got, obs_t'{S_HALT, 2'd1, 32'd1, 32'd1});
        end
        start = 1'b1;
        step  = 1'b1;
        cyc();
        start = 1'b0;
        step  = 1'b0;
        got = {state, halt_cause, instr_cnt, cycle_cnt};
        n_checks++;
        if (got !== obs_t'{S_RST, 2'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL start_vs_step got %h want %h", got, obs_t'{S_RST, 2'd0, 32'd0, 32'd0});
        end
        bp_valid = 1'b0;
    endtask

    task automatic test_midrun_reset();
        do_start();
        #2 rstn = 1'b1;
        #1;
        n_checks++;
        if (state !== S_IDLE || core_rst !== 1'b1 || core_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset got state=%0d rst=%b en=%b want 0/1/0", state, core_rst, core_en);
        end
        rstn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        bp_valid = 1'b0;
        retire   = 1'b0;
        do_start();
        repeat (49) cyc();
        n_checks++;
        if (state !== S_RUN || cycle_cnt !== 32'd49) begin
            n_fail++;
            $display("FAIL wd_pre got state=%0d cc=%0d want 2/49", state, cycle_cnt);
        end
        cyc();
`ifdef XGRISCV_RUN_WATCHDOG_EN
        n_checks++;
        if (state !== S_TMO || timeout !== 1'b1 || cycle_cnt !== 32'd50 ||
            core_en !== 1'b0 || core_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_fire got state=%0d tmo=%b cc=%0d en=%b rst=%b want 5/1/50/0/0",
                     state, timeout, cycle_cnt, core_en, core_rst);
        end
        resume = 1'b1;
        step   = 1'b1;
        repeat (3) cyc();
        resume = 1'b0;
        step   = 1'b0;
        n_checks++;
        if (state !== S_TMO || cycle_cnt !== 32'd50) begin
            n_fail++;
            $display("FAIL wd_sticky got state=%0d cc=%0d want 5/50", state, cycle_cnt);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_checks++;
        if (state !== S_RST || timeout !== 1'b0 || cycle_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL wd_clear got state=%0d tmo=%b cc=%0d want 1/0/0", state, timeout, cycle_cnt);
        end
`else
        repeat (30) cyc();
        n_checks++;
        if (state !== S_RUN || timeout !== 1'b0 || cycle_cnt !== 32'd80) begin
            n_fail++;
            $display("FAIL wd_off got state=%0d tmo=%b cc=%0d want 2/0/80", state, timeout, cycle_cnt);
        end
`endif
    endtask

    initial begin
        rstn     = 1'b0;
        start    = 1'b0;
        resume   = 1'b0;
        step     = 1'b0;
        halt_req = 1'b0;
        bp_valid = 1'b0;
        retire   = 1'b0;
        bp_addr  = 32'h0;
        pcW      = 32'h0;
        test_reset();
        test_start();
        test_breakpoint();
        test_step();
        test_resume_halt();
        test_simultaneous();
        test_midrun_reset();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
